// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file and its dump engine.
// Contents: dump state encoding, default widths, and the hard-wired zero register index.
package regfile_pkg;
   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_SEND = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_e;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int ZERO_IDX       = 0;
endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: streams every register in address order over a valid/ready handshake.
// Ports: clk, reset (async active-low), dump_start/dump_ready (requests),
//        rd_addr/rd_data (dedicated array read port with zero/bypass applied by the parent),
//        dump_busy/dump_valid/dump_addr/dump_data/dump_done (beat stream and status).
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dump_start,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  dump_busy,
   output logic                  dump_valid,
   output logic [ADDR_WIDTH-1:0] dump_addr,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_done
);
   dump_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= DUMP_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // The read port always looks at the beat that would be loaded next, so a
   // write landing on the same edge is captured through the parent's bypass.
   assign rd_addr = (state_q == DUMP_IDLE) ? '0 : addr_q + ADDR_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         DUMP_IDLE: if (dump_start) begin
            state_d = DUMP_SEND;
            addr_d  = '0;
            data_d  = rd_data;
         end
         DUMP_SEND: if (dump_ready) begin
            if (&addr_q) state_d = DUMP_DONE;
            else begin
               addr_d = rd_addr;
               data_d = rd_data;
            end
         end
         DUMP_DONE: state_d = DUMP_IDLE;
         default:   state_d = DUMP_IDLE;
      endcase
   end

   always_comb begin
      dump_valid = (state_q == DUMP_SEND);
      dump_busy  = (state_q != DUMP_IDLE);
      dump_done  = (state_q == DUMP_DONE);
      dump_addr  = addr_q;
      dump_data  = data_q;
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with write bypass and debug dump.
// Ports: clk, reset (async active-low, clears the array),
//        A_RD/RD (NUM_RD packed combinational read ports), A3/WD3/WE3 (write port),
//        dump_start/dump_ready in, dump_busy/dump_valid/dump_addr/dump_data/dump_done out.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] A_RD,
   output logic [NUM_RD*DATA_WIDTH-1:0] RD,
   input  logic [ADDR_WIDTH-1:0]        A3,
   input  logic [DATA_WIDTH-1:0]        WD3,
   input  logic                         WE3,
   input  logic                         dump_start,
   output logic                         dump_busy,
   output logic                         dump_valid,
   input  logic                         dump_ready,
   output logic [ADDR_WIDTH-1:0]        dump_addr,
   output logic [DATA_WIDTH-1:0]        dump_data,
   output logic                         dump_done
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_IDX);

   logic [DATA_WIDTH-1:0] ram_q [DEPTH];
   logic [DATA_WIDTH-1:0] ram_d [DEPTH];
   logic                  wr_ok;
   logic [ADDR_WIDTH-1:0] dump_rd_addr;
   logic [DATA_WIDTH-1:0] dump_rd_data;

   // A write to x0 is dropped entirely, so it must not be bypassed either.
   assign wr_ok = WE3 && !((ZERO_REG != 0) && (A3 == ZERO_A));

   always_comb begin
      ram_d = ram_q;
      if (wr_ok) ram_d[A3] = WD3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ram_q <= '{default: '0};
      else        ram_q <= ram_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      assign a = A_RD[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign RD[i*DATA_WIDTH +: DATA_WIDTH] =
         ((ZERO_REG != 0) && (a == ZERO_A)) ? '0 :
         ((BYPASS != 0) && wr_ok && (A3 == a)) ? WD3 : ram_q[a];
   end

   assign dump_rd_data =
      ((ZERO_REG != 0) && (dump_rd_addr == ZERO_A)) ? '0 :
      ((BYPASS != 0) && wr_ok && (A3 == dump_rd_addr)) ? WD3 : ram_q[dump_rd_addr];

   regfile_dump_fsm #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dump (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .rd_addr    (dump_rd_addr),
      .rd_data    (dump_rd_data),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (4-port bypassing and 2-port non-bypassing builds).
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] a_rd;
   logic [127:0] rd;
   logic [9:0]  a_rd_nb;
   logic [63:0] rd_nb;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic        we3;
   logic        dump_start, dump_ready;
   logic        dump_busy, dump_valid, dump_done;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;
   logic        nb_start;
   logic        nb_busy, nb_valid, nb_done;
   logic [4:0]  nb_addr;
   logic [31:0] nb_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [32];

   always #5 clk = ~clk;

   regfile_mp #(.NUM_RD(4), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .A_RD(a_rd), .RD(rd), .A3(a3), .WD3(wd3), .WE3(we3),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
   );

   regfile_mp #(.NUM_RD(2), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .A_RD(a_rd_nb), .RD(rd_nb), .A3(a3), .WD3(wd3), .WE3(we3),
      .dump_start(nb_start), .dump_busy(nb_busy), .dump_valid(nb_valid),
      .dump_ready(1'b1), .dump_addr(nb_addr), .dump_data(nb_data), .dump_done(nb_done)
   );

   typedef struct {
      logic             we;
      logic [4:0]       a;
      logic [31:0]      d;
      logic [3:0][4:0]  ra;
      logic [3:0][31:0] ex;
   } vec_t;

   function automatic vec_t mk(logic we, logic [4:0] a, logic [31:0] d,
                               logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
                               logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
      vec_t v;
      v.we = we; v.a = a; v.d = d;
      v.ra = {r3, r2, r1, r0};
      v.ex = {e3, e2, e1, e0};
      return v;
   endfunction

   // Reference read: x0 is zero, a pending legal write wins when bypassing, else the stored value.
   function automatic logic [31:0] mread(logic [4:0] a, bit byp);
      if (a == 0) return 32'h0;
      if (byp && we3 && a3 != 0 && a3 == a) return wd3;
      return mem[a];
   endfunction

   function automatic logic [31:0] rdp(int i);
      return rd[i*32 +: 32];
   endfunction

   function automatic logic [31:0] rdnb(int i);
      return rd_nb[i*32 +: 32];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock: the model absorbs the write that the DUT sees at this edge.
   task automatic step();
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      w = we3; a = a3; d = wd3;
      @(posedge clk);
      if (w && a != 0) mem[a] = d;
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
   endtask

   vec_t vec [11];
   int   busy_cnt;
   int   done_seen;

   initial begin
      vec[0]  = mk(1, 0,  32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
      vec[1]  = mk(0, 0,  32'h0,        0, 0, 0, 0, 0, 0, 0, 0);
      vec[2]  = mk(1, 7,  32'hA5A5A5A5, 7, 7, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
      vec[3]  = mk(1, 1,  32'h1,        7, 1, 0, 0, 32'hA5A5A5A5, 1, 0, 0);
      vec[4]  = mk(1, 2,  32'h2,        1, 2, 7, 0, 1, 2, 32'hA5A5A5A5, 0);
      vec[5]  = mk(1, 3,  32'h3,        3, 2, 1, 7, 3, 2, 1, 32'hA5A5A5A5);
      vec[6]  = mk(1, 4,  32'h4,        4, 3, 2, 1, 4, 3, 2, 1);
      vec[7]  = mk(0, 4,  32'h9,        4, 3, 2, 1, 4, 3, 2, 1);
      vec[8]  = mk(1, 31, 32'hFFFFFFFF, 31, 30, 0, 31, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);
      vec[9]  = mk(1, 7,  32'h0,        31, 7, 7, 0, 32'hFFFFFFFF, 0, 0, 0);
      vec[10] = mk(0, 0,  32'h0,        7, 31, 4, 1, 0, 32'hFFFFFFFF, 4, 1);

      reset = 1'b0; we3 = 0; a3 = 0; wd3 = 0; a_rd = '0; a_rd_nb = '0;
      dump_start = 0; dump_ready = 0; nb_start = 0;
      clear_model();
      #2;
      chk("reset_rd0", rdp(0), 0);
      chk("reset_busy", {31'b0, dump_busy}, 0);
      chk("reset_valid", {31'b0, dump_valid}, 0);
      chk("reset_done", {31'b0, dump_done}, 0);
      chk("reset_addr", {27'b0, dump_addr}, 0);
      chk("reset_data", dump_data, 0);
      #6 reset = 1'b1;
      @(posedge clk); #1;

      // Table-driven read/write/bypass vectors starting from the cleared array.
      for (int v = 0; v < 11; v++) begin
         we3 = vec[v].we; a3 = vec[v].a; wd3 = vec[v].d; a_rd = vec[v].ra;
         #1;
         for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_p%0d", v, i), rdp(i), vec[v].ex[i]);
         step();
      end

      // Non-bypassing build sees the old value until the edge; bypassing build sees it now.
      we3 = 1; a3 = 9; wd3 = 32'h00005A5A;
      a_rd = {5'd0, 5'd0, 5'd9, 5'd9}; a_rd_nb = {5'd9, 5'd9};
      #1;
      chk("byp_p0", rdp(0), 32'h5A5A);
      chk("byp_p1", rdp(1), 32'h5A5A);
      chk("nobyp_p0_before", rdnb(0), 0);
      chk("nobyp_p1_before", rdnb(1), 0);
      step();
      we3 = 0;
      #1;
      chk("nobyp_p0_after", rdnb(0), 32'h5A5A);
      chk("nobyp_p1_after", rdnb(1), 32'h5A5A);

      // Randomized traffic against the array model, biased to hit bypass cases.
      for (int n = 0; n < 300; n++) begin
         we3 = 1'($urandom); a3 = 5'($urandom); wd3 = $urandom;
         a_rd = 20'($urandom); a_rd_nb = 10'($urandom);
         if ($urandom_range(0, 3) == 0) a_rd[4:0] = a3;
         if ($urandom_range(0, 3) == 0) a_rd_nb[9:5] = a3;
         #1;
         for (int i = 0; i < 4; i++)
            chk($sformatf("rnd%0d_p%0d", n, i), rdp(i), mread(a_rd[i*5 +: 5], 1));
         for (int i = 0; i < 2; i++)
            chk($sformatf("rnd%0d_nb%0d", n, i), rdnb(i), mread(a_rd_nb[i*5 +: 5], 0));
         step();
      end

      // Asynchronous reset mid-cycle clears the array immediately.
      we3 = 1; a3 = 5; wd3 = 32'hDEADBEEF;
      step();
      we3 = 0; a_rd = {5'd0, 5'd0, 5'd0, 5'd5};
      #1;
      chk("pre_reset_x5", rdp(0), 32'hDEADBEEF);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_x5", rdp(0), 0);
      chk("async_reset_busy", {31'b0, dump_busy}, 0);
      chk("async_reset_data", dump_data, 0);
      clear_model();
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // Full dump of xi = i*0x11 with the consumer always ready.
      for (int i = 1; i < 32; i++) begin
         we3 = 1; a3 = 5'(i); wd3 = 32'(i * 'h11);
         step();
      end
      we3 = 0;
      dump_ready = 1; dump_start = 1;
      step();
      dump_start = 0;
      busy_cnt = 0;
      for (int b = 0; b < 32; b++) begin
         chk($sformatf("full_valid%0d", b), {31'b0, dump_valid}, 1);
         chk($sformatf("full_addr%0d", b), {27'b0, dump_addr}, 32'(b));
         chk($sformatf("full_data%0d", b), dump_data, 32'(b * 'h11));
         chk($sformatf("full_nodone%0d", b), {31'b0, dump_done}, 0);
         if (dump_busy) busy_cnt++;
         step();
      end
      chk("full_done", {31'b0, dump_done}, 1);
      chk("full_done_valid", {31'b0, dump_valid}, 0);
      if (dump_busy) busy_cnt++;
      step();
      chk("full_done_pulse", {31'b0, dump_done}, 0);
      chk("full_idle_busy", {31'b0, dump_busy}, 0);
      chk("full_busy_cycles", 32'(busy_cnt), 33);

      // Back-pressure, write during stall, same-edge capture, ignored restart, reset abort.
      dump_start = 1;
      step();
      dump_start = 0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("bp_addr%0d", b), {27'b0, dump_addr}, 32'(b));
         dump_start = (b == 2);
         step();
         dump_start = 0;
      end
      chk("bp_addr4", {27'b0, dump_addr}, 4);
      chk("bp_data4", dump_data, 32'h44);
      dump_ready = 0;
      for (int s = 0; s < 3; s++) begin
         we3 = (s == 0); a3 = 4; wd3 = 32'h0000FFFF;
         step();
         we3 = 0;
         chk($sformatf("stall%0d_valid", s), {31'b0, dump_valid}, 1);
         chk($sformatf("stall%0d_addr", s), {27'b0, dump_addr}, 4);
         chk($sformatf("stall%0d_data", s), dump_data, 32'h44);
      end
      a_rd = {5'd0, 5'd0, 5'd0, 5'd4};
      #1;
      chk("stall_x4_written", rdp(0), 32'h0000FFFF);
      dump_ready = 1; we3 = 1; a3 = 5; wd3 = 32'h0000BEEF;
      step();
      we3 = 0;
      chk("beat5_addr", {27'b0, dump_addr}, 5);
      chk("beat5_data", dump_data, 32'h0000BEEF);
      for (int b = 6; b <= 10; b++) begin
         step();
         chk($sformatf("bp_addr%0d", b), {27'b0, dump_addr}, 32'(b));
         chk($sformatf("bp_data%0d", b), dump_data, mem[b]);
      end
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", {31'b0, dump_busy}, 0);
      chk("abort_valid", {31'b0, dump_valid}, 0);
      chk("abort_addr", {27'b0, dump_addr}, 0);
      clear_model();
      #1 reset = 1'b1;
      @(posedge clk); #1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (dump_done || dump_busy) done_seen++;
         step();
      end
      chk("abort_no_done", 32'(done_seen), 0);
      a_rd = {5'd0, 5'd0, 5'd5, 5'd4};
      #1;
      chk("abort_x4_cleared", rdp(0), 0);
      chk("abort_x5_cleared", rdp(1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
